// File: rtl/clock_sequencer.sv
// rtl/clock_sequencer.sv - time-of-day sequencer with cascaded sec/min/hour fields and a SET-mode FSM
//
// Purpose: counts seconds, minutes and hours from a one-cycle tick while in RUN,
// and lets the user step one field at a time with button pulses while in a SET mode.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous, active-high reset
//   tick       one-cycle enable that advances seconds in RUN
//   btn_mode   one-cycle pulse, steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
//   btn_inc    one-cycle pulse, increments the selected field in a SET mode
//   load       one-cycle pulse, presets all three fields from load_sec/min/hour
//   load_*     preset values
//   sec/min/hour  registered field values
//   mode       00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink      display-blink flag for the selected field
//   day_pulse  one-cycle pulse on the full-day rollover
module clock_sequencer #(
    parameter int WIDTH    = 6,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_sec,
    input  logic [WIDTH-1:0] load_min,
    input  logic [WIDTH-1:0] load_hour,
    output logic [WIDTH-1:0] sec,
    output logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] hour,
    output logic [1:0]       mode,
    output logic             blink,
    output logic             day_pulse
);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_SEC  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] SEC_LIM  = SEC_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_LIM  = MIN_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] HOUR_LIM = HOUR_MAX[WIDTH-1:0];

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] sec_q, sec_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] hour_q, hour_d;
    logic             blink_q, blink_d;
    logic             day_q, day_d;

    // Values >= limit wrap to zero, so out-of-range presets recover on the next step.
    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] lim);
        return (v >= lim) ? '0 : v + WIDTH'(1);
    endfunction

    // Cascade result for one RUN tick; each carry needs every lower field to wrap.
    logic             sec_wrap, min_wrap, hour_wrap;
    logic [WIDTH-1:0] run_sec, run_min, run_hour;
    logic             run_day;

    assign sec_wrap  = (sec_q  >= SEC_LIM);
    assign min_wrap  = (min_q  >= MIN_LIM);
    assign hour_wrap = (hour_q >= HOUR_LIM);
    assign run_sec   = wrap_inc(sec_q, SEC_LIM);
    assign run_min   = sec_wrap ? wrap_inc(min_q, MIN_LIM) : min_q;
    assign run_hour  = (sec_wrap && min_wrap) ? wrap_inc(hour_q, HOUR_LIM) : hour_q;
    assign run_day   = sec_wrap && min_wrap && hour_wrap;

    always_comb begin
        mode_d  = mode_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        blink_d = blink_q;
        day_d   = 1'b0;

        if (load) begin
            sec_d  = load_sec;
            min_d  = load_min;
            hour_d = load_hour;
        end else if (btn_mode) begin
            // A tick coinciding with leaving RUN still counts so no second is lost.
            if (mode_q == MODE_RUN && tick) begin
                sec_d  = run_sec;
                min_d  = run_min;
                hour_d = run_hour;
                day_d  = run_day;
            end
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                MODE_SET_MIN:  mode_d = MODE_SET_SEC;
                default:       mode_d = MODE_RUN;
            endcase
            blink_d = 1'b0;
        end else if (btn_inc && mode_q != MODE_RUN) begin
            // Manual stepping never carries into neighbouring fields.
            case (mode_q)
                MODE_SET_HOUR: hour_d = wrap_inc(hour_q, HOUR_LIM);
                MODE_SET_MIN:  min_d  = wrap_inc(min_q, MIN_LIM);
                default:       sec_d  = wrap_inc(sec_q, SEC_LIM);
            endcase
        end else if (tick) begin
            if (mode_q == MODE_RUN) begin
                sec_d  = run_sec;
                min_d  = run_min;
                hour_d = run_hour;
                day_d  = run_day;
            end else begin
                blink_d = ~blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            blink_q <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            blink_q <= blink_d;
            day_q   <= day_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign mode      = mode_q;
    assign blink     = blink_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// tb/tb_clock_sequencer.sv - self-checking bench for clock_sequencer
module tb_clock_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [5:0] load_hour;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    int m_sec, m_min, m_hour, m_mode, m_blink, m_day;
    bit model_valid = 0;

    clock_sequencer #(
        .WIDTH(6), .SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .load(load), .load_sec(load_sec),
        .load_min(load_min), .load_hour(load_hour), .sec(sec), .min(min),
        .hour(hour), .mode(mode), .blink(blink), .day_pulse(day_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bump(input int v, input int lim);
        return (v >= lim) ? 0 : v + 1;
    endfunction

    // One second of wall-clock time: carries ripple only through wrapping fields.
    task automatic advance_clock();
        bit s_w, m_w, h_w;
        s_w = (m_sec >= 59);
        m_w = (m_min >= 59);
        h_w = (m_hour >= 23);
        m_sec = bump(m_sec, 59);
        if (s_w) m_min = bump(m_min, 59);
        if (s_w && m_w) m_hour = bump(m_hour, 23);
        m_day = (s_w && m_w && h_w) ? 1 : 0;
    endtask

    task automatic model_step(input bit r, input bit ld, input bit bm, input bit bi, input bit tk);
        m_day = 0;
        if (r) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_blink = 0;
            model_valid = 1;
        end else if (ld) begin
            m_sec = int'(load_sec); m_min = int'(load_min); m_hour = int'(load_hour);
        end else if (bm) begin
            if (m_mode == 0 && tk) advance_clock();
            m_mode = (m_mode + 1) % 4;
            m_blink = 0;
        end else if (bi && m_mode != 0) begin
            if (m_mode == 1) m_hour = bump(m_hour, 23);
            else if (m_mode == 2) m_min = bump(m_min, 59);
            else m_sec = bump(m_sec, 59);
        end else if (tk) begin
            if (m_mode == 0) advance_clock();
            else m_blink = 1 - m_blink;
        end
    endtask

    // Inputs change at the falling edge; the model follows each rising edge.
    task automatic cyc(input bit r, input bit ld, input bit bm, input bit bi, input bit tk);
        rst = r; load = ld; btn_mode = bm; btn_inc = bi; tick = tk;
        @(posedge clk);
        model_step(r, ld, bm, bi, tk);
        @(negedge clk);
        rst = 0; load = 0; btn_mode = 0; btn_inc = 0; tick = 0;
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_sec",   sec,       m_sec);
            chk("model_min",   min,       m_min);
            chk("model_hour",  hour,      m_hour);
            chk("model_mode",  mode,      m_mode);
            chk("model_blink", blink,     m_blink);
            chk("model_day",   day_pulse, m_day);
        end
    end

    task automatic set_load(input int h, input int m, input int s);
        load_hour = h[5:0]; load_min = m[5:0]; load_sec = s[5:0];
    endtask

    initial begin
        rst = 1; load = 0; btn_mode = 0; btn_inc = 0; tick = 0;
        load_sec = 0; load_min = 0; load_hour = 0;
        @(negedge clk);

        // Reset then three ticks
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_sec", sec, 0); chk("rst_mode", mode, 0);
        chk("rst_blink", blink, 0); chk("rst_day", day_pulse, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("tick3_sec", sec, 3); chk("tick3_min", min, 0); chk("tick3_hour", hour, 0);

        // Day rollover
        set_load(23, 59, 58);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("pre_roll_sec", sec, 59); chk("pre_roll_day", day_pulse, 0);
        cyc(0, 0, 0, 0, 1);
        chk("roll_sec", sec, 0); chk("roll_min", min, 0); chk("roll_hour", hour, 0);
        chk("roll_day", day_pulse, 1);
        cyc(0, 0, 0, 0, 0);
        chk("post_roll_day", day_pulse, 0);

        // SET_HOUR stepping with interleaved ticks
        set_load(23, 15, 30);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("set_hour_mode", mode, 1);
        cyc(0, 0, 0, 1, 0);
        chk("hour_wrap", hour, 0);
        cyc(0, 0, 0, 0, 1);
        chk("set_tick_blink", blink, 1); chk("set_tick_sec", sec, 30);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("inc5_hour", hour, 4); chk("inc5_min", min, 15);
        chk("inc5_sec", sec, 30); chk("inc5_blink", blink, 0);

        // SET_MIN wrap with no carry, then back to RUN
        cyc(0, 0, 1, 0, 0);
        chk("set_min_mode", mode, 2);
        set_load(4, 59, 30);
        cyc(0, 1, 0, 0, 0);
        chk("load_keeps_mode", mode, 2);
        cyc(0, 0, 0, 1, 0);
        chk("min_wrap", min, 0); chk("min_no_carry", hour, 4);
        cyc(0, 0, 0, 0, 1);
        chk("blink_on", blink, 1);
        cyc(0, 0, 1, 0, 0);
        chk("set_sec_mode", mode, 3); chk("blink_clr", blink, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        chk("run_mode", mode, 0); chk("run_blink", blink, 0);

        // Load beats btn_mode and tick; btn_mode beats btn_inc
        set_load(5, 6, 7);
        cyc(0, 1, 1, 0, 1);
        chk("prio_hour", hour, 5); chk("prio_min", min, 6);
        chk("prio_sec", sec, 7); chk("prio_mode", mode, 0);
        cyc(0, 0, 1, 1, 0);
        chk("bm_bi_mode", mode, 1); chk("bm_bi_hour", hour, 5);

        // Reset overrides activity in SET_SEC
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("sset_blink", blink, 1);
        cyc(1, 0, 0, 1, 1);
        chk("rst2_sec", sec, 0); chk("rst2_hour", hour, 0);
        chk("rst2_mode", mode, 0); chk("rst2_blink", blink, 0);

        // Out-of-range preset wraps with carry
        set_load(0, 0, 62);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("oor_sec", sec, 0); chk("oor_min", min, 1);

        // Tick applied alongside leaving RUN
        cyc(0, 0, 1, 0, 1);
        chk("bm_tick_sec", sec, 1); chk("bm_tick_mode", mode, 1);

        cyc(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
- Time-of-day controller that sequences three cascaded wrap-around fields: seconds, minutes and hours.
- Runs the cascade from a one-cycle tick enable while in RUN mode.
- In SET modes, freezes time and lets a user step one selected field with debounced button pulses.
- Sits between the prescaler/button-conditioning logic and the display driver.

Parameters:
- WIDTH, 6, bit width of every field output and load input.
- SEC_MAX, 59, last seconds value before wrap to 0.
- MIN_MAX, 59, last minutes value before wrap to 0.
- HOUR_MAX, 23, last hours value before wrap to 0.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle enable, nominally 1 Hz; advances seconds in RUN.
- btn_mode  input  1  one-cycle pulse; steps the mode FSM.
- btn_inc  input  1  one-cycle pulse; increments the selected field in SET modes.
- load  input  1  one-cycle pulse; presets all three fields.
- load_sec, load_min, load_hour  input  WIDTH each  preset values applied on load.
- sec, min, hour  output  WIDTH each  registered field values.
- mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- blink  output  1  display-blink flag for the selected field.
- day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (rst=1 at a clk edge): sec=min=hour=0, mode=RUN, blink=0, day_pulse=0. Reset overrides every other input in the same cycle.
- All outputs are registered. Every effect appears on the outputs at the clk edge that samples the causing pulse (latency 1 cycle).
- Priority below reset, highest first: load, btn_mode, btn_inc, tick.
- load:
  - sec/min/hour take load_sec/min/hour verbatim; mode is unchanged; day_pulse=0.
  - A tick, btn_inc or btn_mode in the same cycle is ignored.
- FSM, on btn_mode: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - A btn_inc in the same cycle is ignored.
  - A tick in the same cycle is still applied when the current state is RUN. When the current state is a SET state, the tick only toggles blink.
- Wrap rule for every field: if value >= MAX then next = 0 (wrap), else next = value + 1. Out-of-range loaded values therefore wrap to 0 on their next increment.
- RUN, on tick:
  - sec advances.
  - min advances only when sec wraps in the same cycle.
  - hour advances only when min wraps in the same cycle.
  - day_pulse=1 for exactly one cycle when hour wraps; otherwise 0.
- SET states:
  - tick never changes any field.
  - btn_inc advances only the selected field by the wrap rule, with no carry into other fields.
  - day_pulse stays 0.
- blink:
  - 0 in RUN.
  - Toggles on each tick while in a SET state.
  - Cleared to 0 on every mode transition.
- Back-to-back pulses on consecutive cycles are each honoured. No minimum spacing between pulses.

Test Plan:
- rst=1 for 2 cycles, then 3 ticks -> sec=3, min=0, hour=0, mode=00.
- load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00; day_pulse=1 only in the cycle after the second tick.
- btn_mode x1, then btn_inc x5 -> mode=01, hour advances 23->0->1->2->3->4; min and sec unchanged; ticks in between leave the fields frozen and toggle blink.
- In SET_MIN with min=59, btn_inc -> min=0 and hour unchanged (no carry). Then btn_mode x2 -> mode=00, blink=0.
- Same-cycle load, btn_mode and tick from RUN with load 05:06:07 -> fields=05:06:07, mode=00. Next cycle btn_mode plus btn_inc -> mode=01, hour still 5.
- rst asserted during SET_SEC with tick and btn_inc active -> next cycle all fields 0, mode=00, blink=0, day_pulse=0. Load value sec=62 followed by one tick -> sec=0, min+1.
